// File: rtl/armleobus_mem_responder.sv
// armleobus_mem_responder: wait-state memory slave for ArmleoBUS; registered outputs, byte-strobed writes.
// Define ARMLEOBUS_MEM_RESPONDER_BURST_EN to accept incrementing multi-beat bursts.
`ifndef ARMLEOBUS_CMD_READ
`define ARMLEOBUS_CMD_READ 3'd1
`endif
`ifndef ARMLEOBUS_CMD_WRITE
`define ARMLEOBUS_CMD_WRITE 3'd2
`endif
`ifndef ARMLEOBUS_RESPONSE_SUCCESS
`define ARMLEOBUS_RESPONSE_SUCCESS 3'd0
`endif
`ifndef ARMLEOBUS_INVALID_OPERATION
`define ARMLEOBUS_INVALID_OPERATION 3'd1
`endif
`ifndef ARMLEOBUS_UNKNOWN_ADDRESS
`define ARMLEOBUS_UNKNOWN_ADDRESS 3'd3
`endif
module armleobus_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transaction,
  input  logic [2:0]  cmd,
  input  logic [33:0] address,
  input  logic [3:0]  burstcount,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbyte_enable,
  output logic        transaction_done,
  output logic [2:0]  transaction_response,
  output logic [31:0] rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, NEXT} state_t;
  state_t state, state_n;
  logic [3:0] cnt, rem;
  logic [2:0] lat_cmd;
  logic [33:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0] lat_wbe;
  logic lat_bad;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic sample, sample_bad, in_wait, enter_resp;
  logic [2:0] e_cmd, resp_n;
  logic [33:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0] e_wbe;
  logic e_bad;
  logic [DEPTH_LOG2-1:0] idx;
`ifdef ARMLEOBUS_MEM_RESPONDER_BURST_EN
  logic [34:0] addr_inc;
  logic seq_err;
`endif
  always_comb begin
    in_wait = state == WAIT;
    sample = transaction && (state == IDLE || state == NEXT);
`ifdef ARMLEOBUS_MEM_RESPONDER_BURST_EN
    // the carry bit makes a wrap past 2**34 compare unequal
    addr_inc = {1'b0, lat_addr} + 35'd4;
    seq_err = cmd != lat_cmd || addr_inc != {1'b0, address};
    sample_bad = state == IDLE ? burstcount == 4'd0 : seq_err;
`else
    sample_bad = burstcount == 4'd0 || burstcount > 4'd1;
`endif
    // WAIT works from latched values; a zero-wait beat responds straight from the inputs
    e_cmd = in_wait ? lat_cmd : cmd;
    e_addr = in_wait ? lat_addr : address;
    e_wdata = in_wait ? lat_wdata : wdata;
    e_wbe = in_wait ? lat_wbe : wbyte_enable;
    e_bad = in_wait ? lat_bad : sample_bad;
    enter_resp = (sample && WAIT_CYCLES == 0) || (in_wait && cnt == 4'd1);
    idx = e_addr[DEPTH_LOG2+1:2];
    resp_n = e_addr[1:0] != 2'b00 ? `ARMLEOBUS_INVALID_OPERATION :
             (e_cmd != `ARMLEOBUS_CMD_READ && e_cmd != `ARMLEOBUS_CMD_WRITE) ? `ARMLEOBUS_INVALID_OPERATION :
             e_bad ? `ARMLEOBUS_INVALID_OPERATION :
             |e_addr[33:DEPTH_LOG2+2] ? `ARMLEOBUS_UNKNOWN_ADDRESS : `ARMLEOBUS_RESPONSE_SUCCESS;
    state_n = state;
    if (sample) state_n = WAIT_CYCLES == 0 ? RESPOND : WAIT;
    else if (state == NEXT) state_n = IDLE;
    else if (in_wait) state_n = cnt == 4'd1 ? RESPOND : WAIT;
`ifdef ARMLEOBUS_MEM_RESPONDER_BURST_EN
    else if (state == RESPOND) state_n = (transaction_response == `ARMLEOBUS_RESPONSE_SUCCESS && rem > 4'd1) ? NEXT : IDLE;
`else
    else if (state == RESPOND) state_n = IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      lat_cmd <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_wbe <= '0;
      lat_bad <= 1'b0;
      transaction_done <= 1'b0;
      transaction_response <= `ARMLEOBUS_RESPONSE_SUCCESS;
      rdata <= '0;
    end else begin
      state <= state_n;
      transaction_done <= enter_resp;
      if (sample) begin
        lat_cmd <= cmd;
        lat_addr <= address;
        lat_wdata <= wdata;
        lat_wbe <= wbyte_enable;
        lat_bad <= sample_bad;
        cnt <= 4'(WAIT_CYCLES);
        if (state == IDLE) rem <= burstcount;
      end else if (in_wait) cnt <= cnt - 4'd1;
      if (state == RESPOND && state_n == NEXT) rem <= rem - 4'd1;
      if (enter_resp) begin
        transaction_response <= resp_n;
        rdata <= (resp_n == `ARMLEOBUS_RESPONSE_SUCCESS && e_cmd == `ARMLEOBUS_CMD_READ) ? mem[idx] : '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && enter_resp && resp_n == `ARMLEOBUS_RESPONSE_SUCCESS && e_cmd == `ARMLEOBUS_CMD_WRITE)
      for (int i = 0; i < 4; i++)
        if (e_wbe[i]) mem[idx][8*i +: 8] <= e_wdata[8*i +: 8];
endmodule
